rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port between the in-order pipeline writeback and the multi-cycle multiply/divide unit (MDU).
- Tracks MDU destination registers that are still in flight in a scoreboard, and raises a decode stall when an instruction touches one of them.
- Sits between the WB stage, the MDU result interface and the register file's write port (wen/waddr/wdata).

Parameters:
- DATA_WIDTH, 32, write-data width.
- ADDR_WIDTH, 5, register address width; 2^ADDR_WIDTH registers; register 0 is hard-wired zero.
- DEPTH, 2, MDU result buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- pipe_wen  in  1  pipeline WB write request; never backpressured.
- pipe_waddr  in  ADDR_WIDTH  pipeline WB destination.
- pipe_wdata  in  DATA_WIDTH  pipeline WB data.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  block can accept an MDU result this cycle.
- mdu_waddr  in  ADDR_WIDTH  MDU result destination.
- mdu_wdata  in  DATA_WIDTH  MDU result data.
- issue_valid  in  1  an MDU op leaves decode this cycle.
- issue_waddr  in  ADDR_WIDTH  destination of the issued MDU op.
- dec_rs  in  ADDR_WIDTH  decode source 1.
- dec_rt  in  ADDR_WIDTH  decode source 2.
- dec_dst_valid  in  1  decode instruction writes a register.
- dec_dst  in  ADDR_WIDTH  decode destination.
- stall  out  1  decode must hold (combinational).
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at posedge):
  - buffer emptied (count=0, pointers=0), pending[] all 0, err=0.
  - While rst is high: mdu_ready=0, rf_wen=0, stall=0; no handshake completes.
  - Reset mid-operation discards buffered results and pending bits.
- Write-port selection (combinational; same-cycle, zero latency), priority order:
  1. pipe_wen=1 and pipe_waddr!=0 -> pipeline data.
  2. Else buffer non-empty -> buffer head; pop at posedge.
  3. Else MDU accept this cycle with mdu_waddr!=0 -> MDU data bypasses the buffer.
  4. Else rf_wen=0; rf_waddr/rf_wdata = 0.
- pipe_wen with pipe_waddr=0 counts as no write and does not block lower sources.
- mdu_ready = (count < DEPTH) and !rst.
- Accept = mdu_valid & mdu_ready.
  - Accepted result not written this cycle -> pushed to tail.
  - Accepted result with mdu_waddr=0 -> dropped; no push, no write.
- Simultaneous pop and push when count=DEPTH is impossible: ready is already low.
- Pop plus push at count<DEPTH -> count unchanged.
- Results leave strictly in arrival order. Pointers wrap modulo DEPTH.
- Scoreboard pending[i], one bit per register, bit 0 constant 0:
  - Set at posedge when issue_valid=1 and issue_waddr=i, i!=0.
  - Cleared at posedge when rf_wen=1 from an MDU source (buffer or bypass) with rf_waddr=i.
  - Set and clear of the same i in the same cycle -> set wins.
  - Issue to an already-pending i -> bit stays 1 and err is set.
  - MDU result for a non-pending i (i!=0) -> written anyway and err is set.
  - err clears only on rst.
- stall = pending[dec_rs] | pending[dec_rt] | (dec_dst_valid & pending[dec_dst]); it uses the current (pre-edge) pending bits.
  - Consequence: in the write cycle stall is still 1; the next cycle stall=0 and a register-file read returns the new value.
- The pipeline never receives backpressure. A sustained stream of pipeline writes starves the buffer; the MDU then sees mdu_ready=0 once the buffer fills.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with mdu_valid=1, pipe_wen=1 -> rf_wen=0, mdu_ready=0, stall=0. After release: mdu_ready=1, count=0, err=0.
- Bypass path: issue_waddr=5; after 3 cycles mdu_valid=1, waddr=5, wdata=0xDEADBEEF, no pipe write.
  - Same cycle: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - dec_rs=5 gives stall=1 in that cycle and stall=0 in the next.
- Conflict and buffering: pipe writes r3 (0x11) every cycle for 4 cycles; MDU offers r7 (0xAA), then r8 (0xBB).
  - Both accepted and buffered; mdu_ready=0 after the second (count=2); rf carries only r3 writes.
  - When the pipe goes idle: r7 is written, then r8, on consecutive cycles; mdu_ready returns to 1.
- Register zero: pipe_wen=1 with waddr=0 while the buffer holds r9 -> r9 is written that cycle. An MDU result to r0 is accepted and dropped; err stays 0.
- Scoreboard corner: pending[4]=1; buffered r4 write and issue_waddr=4 in the same cycle -> pending[4]=1 afterwards and err=0. A second issue to 4 before its result -> err=1, sticky until rst.
- WAW stall: pending[6]=1; dec_dst_valid=1, dec_dst=6, dec_rs=dec_rt=1 -> stall=1 until the cycle after r6's MDU write.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_scheduler
//  Brief    : Arbitrates the register-file write port between pipeline WB and
//             MDU results, with an in-flight scoreboard driving decode stall.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wen,
    input  logic [ADDR_WIDTH-1:0] pipe_waddr,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [ADDR_WIDTH-1:0] mdu_waddr,
    input  logic [DATA_WIDTH-1:0] mdu_wdata,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_waddr,
    input  logic [ADDR_WIDTH-1:0] dec_rs,
    input  logic [ADDR_WIDTH-1:0] dec_rt,
    input  logic                  dec_dst_valid,
    input  logic [ADDR_WIDTH-1:0] dec_dst,
    output logic                  stall,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  err
);

    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam int                 c_NREG      = 2 ** ADDR_WIDTH;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_buf_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_buf_data [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_NREG-1:0]     r_pending;
    logic                  r_err;

    logic w_empty;
    logic w_accept;
    logic w_mdu_nz;
    logic w_pipe_sel;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic w_mdu_wr;
    logic w_issue_nz;
    logic w_issue_err;
    logic w_result_err;

    assign w_empty    = (r_count == '0);
    assign mdu_ready  = (r_count < c_DEPTH_CNT) && !rst;
    assign w_accept   = mdu_valid && mdu_ready;
    assign w_mdu_nz   = (mdu_waddr != '0);
    assign w_pipe_sel = !rst && pipe_wen && (pipe_waddr != '0);

    // A write to r0 from the pipeline leaves the port free for MDU traffic.
    assign w_pop      = !rst && !w_pipe_sel && !w_empty;
    assign w_bypass   = !rst && !w_pipe_sel && w_empty && w_accept && w_mdu_nz;
    assign w_push     = w_accept && w_mdu_nz && !w_bypass;
    assign w_mdu_wr   = w_pop || w_bypass;

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_pipe_sel) begin
            rf_wen   = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
        end else if (w_pop) begin
            rf_wen   = 1'b1;
            rf_waddr = r_buf_addr[r_rd_ptr];
            rf_wdata = r_buf_data[r_rd_ptr];
        end else if (w_bypass) begin
            rf_wen   = 1'b1;
            rf_waddr = mdu_waddr;
            rf_wdata = mdu_wdata;
        end
    end

    // Re-issuing a register whose result retires this same cycle is legal.
    assign w_issue_nz   = issue_valid && (issue_waddr != '0);
    assign w_issue_err  = w_issue_nz && r_pending[issue_waddr]
                          && !(w_mdu_wr && (rf_waddr == issue_waddr));
    assign w_result_err = w_mdu_wr && !r_pending[rf_waddr];

    assign stall = !rst && (r_pending[dec_rs] || r_pending[dec_rt]
                            || (dec_dst_valid && r_pending[dec_dst]));
    assign err   = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_wr_ptr] <= mdu_waddr;
            r_buf_data[r_wr_ptr] <= mdu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_issue_err || w_result_err) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pending[0] <= 1'b0;
        for (int i = 1; i < c_NREG; i++) begin
            if (rst) begin
                r_pending[i] <= 1'b0;
            end else if (w_issue_nz && (issue_waddr == ADDR_WIDTH'(i))) begin
                r_pending[i] <= 1'b1;
            end else if (w_mdu_wr && (rf_waddr == ADDR_WIDTH'(i))) begin
                r_pending[i] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_scheduler
//  Brief    : Self-checking bench; expected writes queued per source, compared
//             as the register-file port fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;

    localparam int c_AW = 5;
    localparam int c_DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_wen;
    logic [c_AW-1:0] pipe_waddr;
    logic [c_DW-1:0] pipe_wdata;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [c_AW-1:0] mdu_waddr;
    logic [c_DW-1:0] mdu_wdata;
    logic            issue_valid;
    logic [c_AW-1:0] issue_waddr;
    logic [c_AW-1:0] dec_rs;
    logic [c_AW-1:0] dec_rt;
    logic            dec_dst_valid;
    logic [c_AW-1:0] dec_dst;
    logic            stall;
    logic            rf_wen;
    logic [c_AW-1:0] rf_waddr;
    logic [c_DW-1:0] rf_wdata;
    logic            err;

    int n_checks   = 0;
    int n_failures = 0;

    logic [c_AW+c_DW-1:0] q_pipe [$];
    logic [c_AW+c_DW-1:0] q_mdu  [$];

    rf_wb_scheduler #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr),
        .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_dst_valid(dec_dst_valid), .dec_dst(dec_dst),
        .stall(stall),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample: any port write must match the head of its source queue.
    task automatic sample();
        logic [c_AW+c_DW-1:0] e;
        @(negedge clk);
        if (rf_wen) begin
            if (pipe_wen && pipe_waddr != '0) begin
                if (q_pipe.size() == 0) check("unexpected_pipe_wr", {rf_waddr, rf_wdata}, '0);
                else begin
                    e = q_pipe.pop_front();
                    check("pipe_wr", {rf_waddr, rf_wdata}, e);
                end
            end else begin
                if (q_mdu.size() == 0) check("unexpected_mdu_wr", {rf_waddr, rf_wdata}, '0);
                else begin
                    e = q_mdu.pop_front();
                    check("mdu_wr", {rf_waddr, rf_wdata}, e);
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic en, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        pipe_wen = en; pipe_waddr = a; pipe_wdata = d;
        if (en && a != '0) q_pipe.push_back({a, d});
    endtask

    task automatic mdu(input logic v, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d, input logic exp_wr);
        mdu_valid = v; mdu_waddr = a; mdu_wdata = d;
        if (exp_wr) q_mdu.push_back({a, d});
    endtask

    task automatic issue(input logic [c_AW-1:0] a);
        issue_valid = 1'b1; issue_waddr = a;
        adv();
        issue_valid = 1'b0; issue_waddr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pipe_wen = 0; pipe_waddr = 0; pipe_wdata = 0;
        mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0; issue_valid = 0; issue_waddr = 0;
        dec_rs = 0; dec_rt = 0; dec_dst_valid = 0; dec_dst = 0;

        // Reset holds everything quiet even with requests present.
        pipe_wen = 1; pipe_waddr = 3; pipe_wdata = 32'h1;
        mdu_valid = 1; mdu_waddr = 2; mdu_wdata = 32'h2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_rf_wen", rf_wen, 0);
            check("rst_ready", mdu_ready, 0);
            check("rst_stall", stall, 0);
            adv();
        end
        rst = 1'b0; pipe(0, 0, 0); mdu(0, 0, 0, 0);
        sample();
        check("post_rst_ready", mdu_ready, 1);
        check("post_rst_err", err, 0);
        check("post_rst_wen", rf_wen, 0);
        adv();

        // Bypass path with RAW stall.
        issue(5);
        dec_rs = 5;
        sample(); check("raw_stall_pending", stall, 1); adv();
        adv();
        mdu(1, 5, 32'hDEADBEEF, 1);
        sample();
        check("bypass_wen", rf_wen, 1);
        check("bypass_addr", rf_waddr, 5);
        check("bypass_data", rf_wdata, 32'hDEADBEEF);
        check("bypass_stall_same", stall, 1);
        adv();
        mdu(0, 0, 0, 0);
        sample();
        check("bypass_stall_next", stall, 0);
        check("bypass_err", err, 0);
        adv();
        dec_rs = 0;

        // Conflict and buffering behind a pipeline stream.
        issue(7); issue(8);
        pipe(1, 3, 32'h11); mdu(1, 7, 32'hAA, 1);
        sample(); check("cf_ready0", mdu_ready, 1); check("cf_addr0", rf_waddr, 3); adv();
        pipe(1, 3, 32'h11); mdu(1, 8, 32'hBB, 1);
        sample(); check("cf_ready1", mdu_ready, 1); adv();
        pipe(1, 3, 32'h11); mdu(0, 0, 0, 0);
        sample(); check("cf_full2", mdu_ready, 0); adv();
        pipe(1, 3, 32'h11);
        sample(); check("cf_full3", mdu_ready, 0); check("cf_addr3", rf_waddr, 3); adv();
        pipe(0, 0, 0);
        sample(); check("cf_drain_r7", rf_waddr, 7); check("cf_drain_ready", mdu_ready, 0); adv();
        sample(); check("cf_drain_r8", rf_waddr, 8); check("cf_ready_back", mdu_ready, 1); adv();
        sample(); check("cf_idle_wen", rf_wen, 0); check("cf_err", err, 0); adv();

        // Register zero handling.
        issue(9);
        pipe(1, 3, 32'h22); mdu(1, 9, 32'h99, 1);
        sample(); adv();
        pipe(1, 0, 32'h33); mdu(0, 0, 0, 0);
        sample(); check("r0_pipe_passes_wen", rf_wen, 1); check("r0_pipe_passes_addr", rf_waddr, 9); adv();
        pipe(0, 0, 0); mdu(1, 0, 32'h55, 0);
        sample(); check("r0_mdu_ready", mdu_ready, 1); check("r0_mdu_nowrite", rf_wen, 0); adv();
        mdu(0, 0, 0, 0);
        sample(); check("r0_err", err, 0); check("r0_ready_after", mdu_ready, 1); adv();

        // Scoreboard: retire and re-issue the same register in one cycle.
        issue(4);
        pipe(1, 3, 32'h44); mdu(1, 4, 32'h4444, 1);
        sample(); adv();
        pipe(0, 0, 0); mdu(0, 0, 0, 0);
        issue_valid = 1; issue_waddr = 4;
        sample(); check("sb_pop_r4", rf_waddr, 4); adv();
        issue_valid = 0; issue_waddr = 0; dec_rs = 4;
        sample(); check("sb_still_pending", stall, 1); check("sb_no_err", err, 0); adv();
        issue(4);
        sample(); check("sb_double_issue_err", err, 1); adv();
        mdu(1, 4, 32'h4545, 1);
        sample(); adv();
        mdu(0, 0, 0, 0);
        sample(); check("sb_cleared", stall, 0); check("sb_err_sticky", err, 1); adv();
        dec_rs = 0;

        // WAW stall on the decode destination.
        issue(6);
        dec_rs = 1; dec_rt = 1; dec_dst = 6; dec_dst_valid = 0;
        sample(); check("waw_gated", stall, 0); adv();
        dec_dst_valid = 1;
        for (int i = 0; i < 2; i++) begin
            sample(); check("waw_stall", stall, 1); adv();
        end
        mdu(1, 6, 32'h66, 1);
        sample(); check("waw_write_cycle", stall, 1); check("waw_addr", rf_waddr, 6); adv();
        mdu(0, 0, 0, 0);
        sample(); check("waw_released", stall, 0); adv();
        dec_dst_valid = 0; dec_rs = 0; dec_rt = 0; dec_dst = 0;

        // Reset mid-operation discards the buffered result and clears err.
        issue(10);
        pipe(1, 3, 32'h77); mdu(1, 10, 32'hAB, 0);
        sample(); adv();
        pipe(0, 0, 0); mdu(0, 0, 0, 0); rst = 1;
        @(negedge clk);
        check("mid_rst_wen", rf_wen, 0);
        check("mid_rst_ready", mdu_ready, 0);
        adv();
        rst = 0; dec_rs = 10;
        sample();
        check("mid_rst_discard", rf_wen, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_pending", stall, 0);
        adv();
        dec_rs = 0;
        sample(); adv();

        check("pipe_queue_empty", q_pipe.size(), 0);
        check("mdu_queue_empty", q_mdu.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
